// File: rtl/spfp_div_seq_if.sv
// Issue/return channel between the FP controller and the sequential SPFP divider.
interface spfp_div_seq_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);
  localparam int W = 1 + EXP_W + MANT_W;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic         div_by_zero;

  modport master (output start, A, B, input busy, valid, result, div_by_zero);
  modport slave  (input start, A, B, output busy, valid, result, div_by_zero);
endinterface

// File: rtl/spfp_div_seq.sv
// Sequential single-precision divider: restoring mantissa division one quotient
// bit per clock, then a single normalise/pack cycle. Normal operands, truncation.
//
//   state  | meaning
//   IDLE   | waiting for start; result/div_by_zero hold last value
//   DIVIDE | one restoring-division step per clock, MANT_W+2 steps
//   NORM   | normalise quotient, pack result, pulse valid
module spfp_div_seq #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = 127
) (
  input  logic          clk,
  input  logic          rst,
  spfp_div_seq_if.slave bus
);
  localparam int QW = MANT_W + 2;
  localparam int RW = MANT_W + 3;
  localparam int DW = MANT_W + 1;
  localparam int CW = $clog2(MANT_W + 2);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(MANT_W + 1);
  localparam logic [EXP_W-1:0] BIAS_E   = EXP_W'(BIAS);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t state, nextState;

  logic [CW-1:0]    counter;
  logic [RW-1:0]    remReg;
  logic [DW-1:0]    divReg;
  logic [QW-1:0]    quot;
  logic [EXP_W-1:0] expA, expB;
  logic             signReg;
  logic             aZero, bZero;

  logic [RW-1:0]    divExt, remDiff, remNext;
  logic             remGe;
  logic [EXP_W-1:0] expNorm;
  logic [MANT_W-1:0] mantNorm;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = DIVIDE;
      DIVIDE:  if (counter == '0) nextState = NORM;
      NORM:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);

  // One restoring step; remainder stays below twice the divisor so the shift never overflows.
  always_comb begin
    divExt  = {{(RW-DW){1'b0}}, divReg};
    remGe   = (remReg >= divExt);
    remDiff = remReg - divExt;
    remNext = remGe ? {remDiff[RW-2:0], 1'b0} : {remReg[RW-2:0], 1'b0};
  end

  // Only the low EXP_W bits of the exponent are packed, so modular arithmetic suffices.
  always_comb begin
    expNorm  = expA - expB + BIAS_E;
    mantNorm = quot[QW-3:0];
    if (quot[QW-1]) begin
      mantNorm = quot[QW-2:1];
    end else begin
      expNorm = expNorm - EXP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter         <= '0;
      remReg          <= '0;
      divReg          <= '0;
      quot            <= '0;
      expA            <= '0;
      expB            <= '0;
      signReg         <= 1'b0;
      aZero           <= 1'b0;
      bZero           <= 1'b0;
      bus.valid       <= 1'b0;
      bus.result      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            remReg  <= {2'b00, 1'b1, bus.A[MANT_W-1:0]};
            divReg  <= {1'b1, bus.B[MANT_W-1:0]};
            quot    <= '0;
            counter <= CNT_LOAD;
            expA    <= bus.A[MANT_W +: EXP_W];
            expB    <= bus.B[MANT_W +: EXP_W];
            signReg <= bus.A[MANT_W+EXP_W] ^ bus.B[MANT_W+EXP_W];
            aZero   <= (bus.A[MANT_W +: EXP_W] == '0);
            bZero   <= (bus.B[MANT_W +: EXP_W] == '0);
          end
        end
        DIVIDE: begin
          quot   <= {quot[QW-2:0], remGe};
          remReg <= remNext;
          if (counter != '0) counter <= counter - CW'(1);
        end
        NORM: begin
          bus.valid <= 1'b1;
          if (bZero) begin
            bus.result      <= {signReg, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            bus.div_by_zero <= 1'b1;
          end else if (aZero) begin
            bus.result      <= {signReg, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            bus.div_by_zero <= 1'b0;
          end else begin
            bus.result      <= {signReg, expNorm, mantNorm};
            bus.div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spfp_div_seq.sv
// Directed-vector bench for spfp_div_seq: results, latency, single valid pulse,
// ignored re-start while busy, and reset abort mid-operation.
module tb_spfp_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spfp_div_seq_if #(.EXP_W(8), .MANT_W(23)) bus ();

  spfp_div_seq #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation; pokeAt re-pulses start mid-flight, rstAt aborts with reset.
  task automatic doOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] expR, input logic expDz,
                      input int pokeAt, input int rstAt);
    int cyc;
    int nValid;
    int latency;
    logic [31:0] gotR;
    logic gotDz;
    nValid  = 0;
    latency = 0;
    gotR    = '0;
    gotDz   = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    cyc = 1;
    checkVal({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
    while (cyc < 45) begin
      @(negedge clk);
      bus.start = (cyc == pokeAt);
      if (cyc == pokeAt) begin
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
      end
      rst = (cyc == rstAt);
      @(posedge clk);
      #1;
      cyc++;
      if (rstAt >= 0 && cyc == rstAt + 1)
        checkVal({tag, " busy after rst"}, {31'b0, bus.busy}, 32'd0);
      if (bus.valid) begin
        if (nValid == 0) begin
          latency = cyc;
          gotR    = bus.result;
          gotDz   = bus.div_by_zero;
        end
        nValid++;
      end
    end
    if (rstAt < 0) begin
      checkVal({tag, " valid count"}, nValid, 32'd1);
      checkVal({tag, " latency"}, latency, 32'd27);
      checkVal({tag, " result"}, gotR, expR);
      checkVal({tag, " dz"}, {31'b0, gotDz}, {31'b0, expDz});
    end else begin
      checkVal({tag, " valid count"}, nValid, 32'd0);
    end
    checkVal({tag, " result hold"}, bus.result, expR);
    checkVal({tag, " dz hold"}, {31'b0, bus.div_by_zero}, {31'b0, expDz});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset busy", {31'b0, bus.busy}, 32'd0);
    checkVal("reset valid", {31'b0, bus.valid}, 32'd0);
    checkVal("reset result", bus.result, 32'h0);
    checkVal("reset dz", {31'b0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    doOp("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, -1, -1);
    doOp("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, -1, -1);
    doOp("-1.5/0.5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, -1, -1);
    doOp("1/-0",     32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, -1, -1);
    doOp("0/2",      32'h00000000, 32'h40000000, 32'h00000000, 1'b0, -1, -1);
    doOp("restart",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0,  5, -1);
    doOp("rst abort",32'h40C00000, 32'h40000000, 32'h00000000, 1'b0, -1, 10);
    doOp("post rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
